// File: rtl/bp_be_issue_queue_if.sv
// Handshake and data bundle between the FE queue, the issue queue and dispatch.
// slave: the issue queue's view. master: the FE/dispatch side that drives it.
interface bp_be_issue_queue_if #(
  parameter int els_p            = 8,
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int bmeta_width_p    = 36,
  parameter int exc_code_width_p = 4
);
  localparam int cnt_w = $clog2(els_p) + 1;

  logic                        fe_v_i;
  logic                        fe_ready_o;
  logic                        fe_exc_not_instr_i;
  logic [exc_code_width_p-1:0] fe_exc_code_i;
  logic [vaddr_width_p-1:0]    fe_pc_i;
  logic [instr_width_p-1:0]    fe_instr_i;
  logic [bmeta_width_p-1:0]    fe_bmeta_i;

  logic                        issue_v_o;
  logic                        issue_yumi_i;
  logic [vaddr_width_p-1:0]    issue_pc_o;
  logic [instr_width_p-1:0]    issue_instr_o;
  logic [bmeta_width_p-1:0]    issue_bmeta_o;
  logic                        issue_exc_not_instr_o;
  logic [exc_code_width_p-1:0] issue_exc_code_o;
  logic                        issue_mem_v_o;
  logic                        issue_fence_v_o;
  logic                        issue_irs1_v_o;
  logic                        issue_irs2_v_o;

  logic                        roll_i;
  logic                        deq_i;
  logic                        clr_i;
  logic                        empty_o;
  logic [cnt_w-1:0]            issue_count_o;

  modport slave (
    input  fe_v_i, fe_exc_not_instr_i, fe_exc_code_i, fe_pc_i, fe_instr_i, fe_bmeta_i,
    input  issue_yumi_i, roll_i, deq_i, clr_i,
    output fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o, issue_bmeta_o,
    output issue_exc_not_instr_o, issue_exc_code_o,
    output issue_mem_v_o, issue_fence_v_o, issue_irs1_v_o, issue_irs2_v_o,
    output empty_o, issue_count_o
  );

  modport master (
    output fe_v_i, fe_exc_not_instr_i, fe_exc_code_i, fe_pc_i, fe_instr_i, fe_bmeta_i,
    output issue_yumi_i, roll_i, deq_i, clr_i,
    input  fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o, issue_bmeta_o,
    input  issue_exc_not_instr_o, issue_exc_code_o,
    input  issue_mem_v_o, issue_fence_v_o, issue_irs1_v_o, issue_irs2_v_o,
    input  empty_o, issue_count_o
  );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Speculative issue queue between the FE queue and dispatch.
// Entries are pre-decoded on enqueue. rptr issues speculatively; cptr marks
// committed entries so roll rewinds rptr to cptr and clr empties everything.
// Optional macro BP_BE_ISSUE_QUEUE_BYPASS_EN: an enqueue into a queue with
// nothing issuable is presented on the issue outputs in the same cycle.
module bp_be_issue_queue #(
  parameter int els_p            = 8,
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int bmeta_width_p    = 36,
  parameter int exc_code_width_p = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_be_issue_queue_if.slave io
);
  localparam int lg_els = $clog2(els_p);
  localparam int ptr_w  = lg_els + 1;

  typedef struct packed {
    logic                        exc;
    logic [exc_code_width_p-1:0] code;
    logic [vaddr_width_p-1:0]    pc;
    logic [instr_width_p-1:0]    instr;
    logic [bmeta_width_p-1:0]    bmeta;
    logic                        mem_v;
    logic                        fence_v;
    logic                        irs1_v;
    logic                        irs2_v;
  } entry_t;

  entry_t           mem_r [els_p];
  entry_t           fe_ent, iss_ent;
  logic [ptr_w-1:0] wptr_r, rptr_r, cptr_r, cptr_n, fill;
  logic             enq, byp, issue_v, yumi_ok;
  logic [6:0]       opc;
  logic             op_load, op_store, op_amo, op_misc, op_sys, op_jalr;
  logic             op_imm, op_imm32, op_br, op_op, op_op32, sfence;

  assign opc      = io.fe_instr_i[6:0];
  assign op_load  = (opc == 7'b0000011);
  assign op_store = (opc == 7'b0100011);
  assign op_amo   = (opc == 7'b0101111);
  assign op_misc  = (opc == 7'b0001111);
  assign op_sys   = (opc == 7'b1110011);
  assign op_jalr  = (opc == 7'b1100111);
  assign op_imm   = (opc == 7'b0010011);
  assign op_imm32 = (opc == 7'b0011011);
  assign op_br    = (opc == 7'b1100011);
  assign op_op    = (opc == 7'b0110011);
  assign op_op32  = (opc == 7'b0111011);
  assign sfence   = op_sys & (io.fe_instr_i[31:25] == 7'b0001001)
                  & (io.fe_instr_i[14:12] == 3'b000) & (io.fe_instr_i[11:7] == 5'd0);

  // Build the stored entry; exceptions carry no operand/unit hints.
  always_comb begin
    fe_ent       = '0;
    fe_ent.exc   = io.fe_exc_not_instr_i;
    fe_ent.code  = io.fe_exc_code_i;
    fe_ent.pc    = io.fe_pc_i;
    fe_ent.instr = io.fe_instr_i;
    fe_ent.bmeta = io.fe_bmeta_i;
    if (!io.fe_exc_not_instr_i) begin
      fe_ent.mem_v   = op_load | op_store | op_amo;
      fe_ent.fence_v = op_misc | sfence;
      fe_ent.irs1_v  = op_jalr | op_load | op_imm | op_imm32 | op_sys
                     | op_br | op_store | op_op | op_op32 | op_amo;
      fe_ent.irs2_v  = op_br | op_store | op_op | op_op32 | op_amo;
    end
  end

  // Occupancy counts everything not yet committed, so issued entries still hold slots.
  assign fill          = wptr_r - cptr_r;
  assign io.fe_ready_o = (fill < ptr_w'(els_p)) & ~io.clr_i;
  assign enq           = io.fe_v_i & io.fe_ready_o;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  assign byp = (rptr_r == wptr_r) & enq & ~io.roll_i;
`else
  assign byp = 1'b0;
`endif

  assign issue_v   = ((rptr_r != wptr_r) & ~io.clr_i) | byp;
  assign iss_ent   = byp ? fe_ent : mem_r[rptr_r[lg_els-1:0]];
  assign yumi_ok   = io.issue_yumi_i & issue_v;
  assign cptr_n    = cptr_r + ptr_w'(io.deq_i);

  assign io.issue_v_o             = issue_v;
  assign io.issue_pc_o            = iss_ent.pc;
  assign io.issue_instr_o         = iss_ent.instr;
  assign io.issue_bmeta_o         = iss_ent.bmeta;
  assign io.issue_exc_not_instr_o = iss_ent.exc;
  assign io.issue_exc_code_o      = iss_ent.code;
  assign io.issue_mem_v_o         = iss_ent.mem_v   & issue_v;
  assign io.issue_fence_v_o       = iss_ent.fence_v & issue_v;
  assign io.issue_irs1_v_o        = iss_ent.irs1_v  & issue_v;
  assign io.issue_irs2_v_o        = iss_ent.irs2_v  & issue_v;
  assign io.empty_o               = (wptr_r == cptr_r);
  assign io.issue_count_o         = rptr_r - cptr_r;

  // Pointer update: clr beats roll beats yumi; roll lands on the post-deq commit point.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else if (io.clr_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_r + ptr_w'(enq);
      cptr_r <= cptr_n;
      if (io.roll_i)   rptr_r <= cptr_n;
      else if (yumi_ok) rptr_r <= rptr_r + ptr_w'(1);
    end
  end

  // Entry storage; bypassed entries are written too so a roll can replay them.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[lg_els-1:0]] <= fe_ent;
  end

`ifndef SYNTHESIS
  // Protocol checks: no consume without valid, no commit past the issue point.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !io.clr_i) begin
      assert (!(io.issue_yumi_i && !issue_v));
      assert (!(io.deq_i && (cptr_r == rptr_r)));
    end
  end
`endif
endmodule

// File: doc/bp_be_issue_queue.md
Name: bp_be_issue_queue

Overview:
Parametrised, multi-entry successor to the BE scheduler front end. It buffers FE fetch and exception packets and pre-decodes each one on enqueue. Instructions issue speculatively toward dispatch, and the block keeps a separate commit pointer so it can roll back on a cache miss or flush on suppress by itself. It sits between the FE queue interface and the dispatch/decoder logic, so no external fe_queue roll/clr/deq handling is needed.

Parameters:
els_p, 8, queue depth; power of 2, >=2
vaddr_width_p, 39, PC/exception vaddr width
instr_width_p, 32, instruction width
bmeta_width_p, 36, branch_metadata_fwd width
exc_code_width_p, 4, FE exception code width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fe_v_i  in  1  FE packet valid
fe_ready_o  out  1  space available (ready-valid)
fe_exc_not_instr_i  in  1  packet is an FE exception
fe_exc_code_i  in  exc_code_width_p  exception code
fe_pc_i  in  vaddr_width_p  PC or exception vaddr
fe_instr_i  in  instr_width_p  instruction
fe_bmeta_i  in  bmeta_width_p  branch metadata
issue_v_o  out  1  head-of-speculative-window entry valid
issue_yumi_i  in  1  dispatch consumes entry
issue_pc_o / issue_instr_o / issue_bmeta_o / issue_exc_not_instr_o / issue_exc_code_o  out  as inputs  stored packet fields
issue_mem_v_o, issue_fence_v_o, issue_irs1_v_o, issue_irs2_v_o  out  1 each  pre-decode bits
roll_i  in  1  rewind speculative pointer to commit pointer
deq_i  in  1  commit oldest issued entry
clr_i  in  1  flush all entries
empty_o  out  1  no uncommitted entries
issue_count_o  out  $clog2(els_p)+1  entries issued but not committed

Behaviour:
- Three pointers, each $clog2(els_p)+1 bits with a wrap bit: wptr (enqueue), rptr (speculative issue), cptr (commit). Invariant: cptr <= rptr <= wptr, taken modulo wrap.
- Reset (async, reset_n_i=0): all pointers 0. fe_ready_o=1, issue_v_o=0, empty_o=1, issue_count_o=0. Data outputs are don't-care; pre-decode outputs are 0 while issue_v_o=0.
- fe_ready_o = (wptr-cptr < els_p) & ~clr_i. Enqueue when fe_v_i & fe_ready_o: the entry is written at wptr[low], and wptr increments.
- Pre-decode is computed on enqueue and stored with the entry. For exception packets, all four bits are 0. For instructions, opcode = instr[6:0]:
  - mem_v: opcode 0000011, 0100011 or 0101111.
  - fence_v: opcode 0001111, or an SFENCE.VMA encoding (opcode 1110011, funct7 0001001, funct3 000, rd 0).
  - irs1_v: JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM, BRANCH, STORE, OP, OP_32, AMO.
  - irs2_v: BRANCH, STORE, OP, OP_32, AMO.
- Issue side:
  - issue_v_o = (rptr != wptr) & ~clr_i. Outputs come from the registered entry at rptr.
  - Minimum latency from enqueue to issue_v_o is 1 cycle.
  - issue_yumi_i & issue_v_o advances rptr. issue_yumi_i without issue_v_o is illegal (assert).
- Commit: deq_i advances cptr. deq_i when cptr==rptr is illegal (assert). The slot is freed, and fe_ready_o reflects it next cycle.
- Priority when signals coincide: clr_i > roll_i > issue_yumi_i.
  - clr_i: wptr=rptr=cptr=0 next cycle; any enqueue, yumi or deq that cycle is discarded.
  - roll_i: rptr <= cptr_next, where cptr_next includes a simultaneous deq_i. A yumi in the same cycle is ignored.
  - A simultaneous enqueue with roll_i is accepted.
- Full: wptr-cptr == els_p gives fe_ready_o=0, even if entries remain unissued.
- Pointer wrap: pointer arithmetic is modulo 2*els_p; full and empty are distinguished by the wrap bit.
- empty_o = (wptr == cptr). issue_count_o = rptr - cptr.
- Reset asserted mid-operation clears everything immediately and asynchronously; there is no partial state.

Optional Feature:
BP_BE_ISSUE_QUEUE_BYPASS_EN
- Defined: when rptr==wptr (nothing issuable) and a packet is enqueued, issue_v_o and all issue outputs, including pre-decode, come combinationally from the fe_* inputs in the same cycle.
  - A yumi that cycle advances both wptr and rptr; the entry is still written so that roll_i can replay it.
  - The bypass is blocked by clr_i and by roll_i.
- Undefined: no bypass; enqueue-to-issue latency is 1 cycle.

Test Plan:
- Reset, enqueue LW x1,0(x2) (0x00012083) at pc 0x80000000 -> next cycle issue_v_o=1, mem_v=1, irs1_v=1, irs2_v=0, fence_v=0, pc=0x80000000.
- Fill 8 entries without issue -> fe_ready_o=0. Issue 8 -> fe_ready_o still 0. One deq -> fe_ready_o=1 next cycle, issue_count_o=7.
- Enqueue A,B,C; issue all three; deq A; roll_i -> next issue is B, issue_count_o=0. Repeat with deq_i in the same cycle as roll_i -> next issue is C.
- Enqueue exception packet (code 2, vaddr 0x1234) -> issue_exc_not_instr_o=1, code 2, pc 0x1234, all pre-decode bits 0.
- Partially filled, with clr_i concurrent with fe_v_i, issue_yumi_i and deq_i -> next cycle empty_o=1, issue_v_o=0, issue_count_o=0, and the concurrent enqueue is dropped.
- Run 3*els_p enqueue/issue/deq cycles across pointer wrap -> no loss or duplication; with BYPASS_EN, an enqueue into an empty queue gives issue_v_o=1 in the same cycle.
